// File: rtl/idli_mem_arb_m.sv
// Arbiter and SQI sequencer for the lo/hi memory pair shared by instruction fetch (FE) and load/store (LS).
// Each access is serialised as CMD, ADDR, optional DUMMY and DATA phases. Each phase carries one nibble per GCK on each memory.
module idli_mem_arb_m #(
  parameter int          MAX_BURST = 4,
  parameter logic [7:0]  CMD_RD    = 8'h03,
  parameter logic [7:0]  CMD_WR    = 8'h02
) (
  input  logic        i_arb_gck,
  input  logic        i_arb_rst,
  input  logic        i_arb_fe_req,
  input  logic [15:0] i_arb_fe_addr,
  input  logic        i_arb_fe_seq,
  output logic        o_arb_fe_gnt,
  output logic        o_arb_fe_vld,
  output logic [15:0] o_arb_fe_data,
  input  logic        i_arb_ls_req,
  input  logic        i_arb_ls_wr,
  input  logic [15:0] i_arb_ls_addr,
  input  logic [15:0] i_arb_ls_wdata,
  output logic        o_arb_ls_gnt,
  output logic        o_arb_ls_done,
  output logic [15:0] o_arb_ls_rdata,
  output logic        o_arb_mem_sck_en,
  output logic        o_arb_mem_cs,
  output logic        o_arb_mem_oe,
  output logic [3:0]  o_arb_mem_lo_sio,
  output logic [3:0]  o_arb_mem_hi_sio,
  input  logic [3:0]  i_arb_mem_lo_sio,
  input  logic [3:0]  i_arb_mem_hi_sio
);

  localparam int BW = $clog2(MAX_BURST) + 1;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_GAP} state_e;

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [15:0]     addr_q, addr_d;
  logic [15:0]     wdata_q, wdata_d;
  logic            wr_q, wr_d;
  logic            own_ls_q, own_ls_d;
  logic            last_ls_q, last_ls_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic [3:0]      lo_sh_q, lo_sh_d, hi_sh_q, hi_sh_d;
  logic            fe_gnt_q, fe_gnt_d, ls_gnt_q, ls_gnt_d;
  logic            fe_vld_q, fe_vld_d, ls_done_q, ls_done_d;
  logic [15:0]     fe_data_q, fe_data_d, ls_rdata_q, ls_rdata_d;
  logic            sck_en_q, sck_en_d, cs_q, cs_d, oe_q, oe_d;
  logic [3:0]      lo_sio_q, lo_sio_d, hi_sio_q, hi_sio_d;

  logic            pick_ls;
  logic            active;
  logic [7:0]      cmd;
  logic [23:0]     addr24;
  logic [3:0]      nib;
  logic [15:0]     rd_word;

  // NOTE: every variable written here gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    own_ls_d   = own_ls_q;
    last_ls_d  = last_ls_q;
    burst_d    = burst_q;
    lo_sh_d    = lo_sh_q;
    hi_sh_d    = hi_sh_q;
    fe_data_d  = fe_data_q;
    ls_rdata_d = ls_rdata_q;
    fe_gnt_d   = 1'b0;
    ls_gnt_d   = 1'b0;
    fe_vld_d   = 1'b0;
    ls_done_d  = 1'b0;
    pick_ls    = i_arb_ls_req && (!i_arb_fe_req || !last_ls_q);
    rd_word    = {hi_sh_q, i_arb_mem_hi_sio, lo_sh_q, i_arb_mem_lo_sio};

    case (state_q)
      S_IDLE: begin
        if (i_arb_fe_req || i_arb_ls_req) begin
          state_d   = S_CMD;
          cnt_d     = 3'd0;
          burst_d   = '0;
          own_ls_d  = pick_ls;
          last_ls_d = pick_ls;
          if (pick_ls) begin
            addr_d   = i_arb_ls_addr;
            wr_d     = i_arb_ls_wr;
            wdata_d  = i_arb_ls_wdata;
            ls_gnt_d = 1'b1;
          end else begin
            addr_d   = i_arb_fe_addr;
            wr_d     = 1'b0;
            fe_gnt_d = 1'b1;
          end
        end
      end
      S_CMD: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = S_ADDR;
          cnt_d   = 3'd0;
        end
      end
      S_ADDR: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd5) begin
          state_d = wr_q ? S_DATA : S_DUMMY;
          cnt_d   = 3'd0;
        end
      end
      S_DUMMY: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = S_DATA;
          cnt_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (cnt_q == 3'd0) begin
          cnt_d   = 3'd1;
          lo_sh_d = i_arb_mem_lo_sio;
          hi_sh_d = i_arb_mem_hi_sio;
        end else begin
          if (own_ls_q) begin
            ls_done_d = 1'b1;
            if (!wr_q) ls_rdata_d = rd_word;
          end else begin
            fe_vld_d  = 1'b1;
            fe_data_d = rd_word;
          end
          // 0xFFFF ends a burst: the chip would continue into 0x10000, which is not this word space.
          if (!own_ls_q && i_arb_fe_seq && addr_q != 16'hFFFF &&
              burst_q < BW'(MAX_BURST - 1) && !i_arb_ls_req) begin
            state_d = S_DATA;
            cnt_d   = 3'd0;
            addr_d  = addr_q + 16'd1;
            burst_d = burst_q + BW'(1);
          end else begin
            state_d = S_GAP;
            cnt_d   = 3'd0;
          end
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
        cnt_d   = 3'd0;
        burst_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 3'd0;
      end
    endcase

    // Pin values are decoded from the state being entered so they are registered alongside it.
    active   = (state_d == S_CMD) || (state_d == S_ADDR) || (state_d == S_DUMMY) || (state_d == S_DATA);
    cs_d     = !active;
    sck_en_d = active;
    oe_d     = 1'b0;
    lo_sio_d = 4'h0;
    hi_sio_d = 4'h0;
    cmd      = wr_d ? CMD_WR : CMD_RD;
    addr24   = {8'h00, addr_q};
    case (cnt_d)
      3'd0:    nib = addr24[23:20];
      3'd1:    nib = addr24[19:16];
      3'd2:    nib = addr24[15:12];
      3'd3:    nib = addr24[11:8];
      3'd4:    nib = addr24[7:4];
      default: nib = addr24[3:0];
    endcase

    case (state_d)
      S_CMD: begin
        oe_d     = 1'b1;
        lo_sio_d = cnt_d[0] ? cmd[3:0] : cmd[7:4];
        hi_sio_d = lo_sio_d;
      end
      S_ADDR: begin
        oe_d     = 1'b1;
        lo_sio_d = nib;
        hi_sio_d = nib;
      end
      S_DATA: begin
        if (wr_d) begin
          oe_d     = 1'b1;
          lo_sio_d = cnt_d[0] ? wdata_q[3:0]  : wdata_q[7:4];
          hi_sio_d = cnt_d[0] ? wdata_q[11:8] : wdata_q[15:12];
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_arb_gck or posedge i_arb_rst) begin
    if (i_arb_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      addr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
      wr_q       <= 1'b0;
      own_ls_q   <= 1'b0;
      last_ls_q  <= 1'b1;
      burst_q    <= '0;
      lo_sh_q    <= 4'h0;
      hi_sh_q    <= 4'h0;
      fe_gnt_q   <= 1'b0;
      ls_gnt_q   <= 1'b0;
      fe_vld_q   <= 1'b0;
      ls_done_q  <= 1'b0;
      fe_data_q  <= 16'h0000;
      ls_rdata_q <= 16'h0000;
      sck_en_q   <= 1'b0;
      cs_q       <= 1'b1;
      oe_q       <= 1'b0;
      lo_sio_q   <= 4'h0;
      hi_sio_q   <= 4'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      own_ls_q   <= own_ls_d;
      last_ls_q  <= last_ls_d;
      burst_q    <= burst_d;
      lo_sh_q    <= lo_sh_d;
      hi_sh_q    <= hi_sh_d;
      fe_gnt_q   <= fe_gnt_d;
      ls_gnt_q   <= ls_gnt_d;
      fe_vld_q   <= fe_vld_d;
      ls_done_q  <= ls_done_d;
      fe_data_q  <= fe_data_d;
      ls_rdata_q <= ls_rdata_d;
      sck_en_q   <= sck_en_d;
      cs_q       <= cs_d;
      oe_q       <= oe_d;
      lo_sio_q   <= lo_sio_d;
      hi_sio_q   <= hi_sio_d;
    end
  end

  assign o_arb_fe_gnt     = fe_gnt_q;
  assign o_arb_fe_vld     = fe_vld_q;
  assign o_arb_fe_data    = fe_data_q;
  assign o_arb_ls_gnt     = ls_gnt_q;
  assign o_arb_ls_done    = ls_done_q;
  assign o_arb_ls_rdata   = ls_rdata_q;
  assign o_arb_mem_sck_en = sck_en_q;
  assign o_arb_mem_cs     = cs_q;
  assign o_arb_mem_oe     = oe_q;
  assign o_arb_mem_lo_sio = lo_sio_q;
  assign o_arb_mem_hi_sio = hi_sio_q;

endmodule
